// File: rtl/core_seq_pkg.sv
// core_seq_pkg: types shared by the multicycle sequencer and its commit FIFO.
//   seq_state_t  - sequencer states FETCH/DECODE/EXEC/MEM/WB
//   commit_rec_t - one retired-instruction record; pc/wdata are stored at the
//                  maximum width (REC_XLEN) and narrowed by the consumer.
package core_seq_pkg;

  localparam int REC_XLEN = 64;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } seq_state_t;

  typedef struct packed {
    logic [REC_XLEN-1:0] pc;
    logic [31:0]         instr;
    logic                wen;
    logic [4:0]          rdc;
    logic [REC_XLEN-1:0] wdata;
    logic                skip;
  } commit_rec_t;

  localparam int REC_W = $bits(commit_rec_t);

endpackage

// File: rtl/core_seq_if.sv
// core_seq_if: commit channel toward the show/difftest consumer.
//   master (sequencer): drives cm_valid and the head-entry fields, reads cm_ready
//   slave  (consumer) : the reverse
interface core_seq_if #(
  parameter int XLEN = 64
);
  logic            cm_valid;
  logic            cm_ready;
  logic [XLEN-1:0] cm_pc;
  logic [31:0]     cm_instr;
  logic            cm_wen;
  logic [4:0]      cm_rdc;
  logic [XLEN-1:0] cm_wdata;
  logic            cm_skip;

  modport master (
    output cm_valid, cm_pc, cm_instr, cm_wen, cm_rdc, cm_wdata, cm_skip,
    input  cm_ready
  );

  modport slave (
    input  cm_valid, cm_pc, cm_instr, cm_wen, cm_rdc, cm_wdata, cm_skip,
    output cm_ready
  );
endinterface

// File: rtl/core_seq_commit_fifo.sv
// commit_fifo: first-word fall-through FIFO of DEPTH entries, W bits each.
//   push/wr_data - write request (taken when not full, or when a pop frees a slot)
//   pop          - read request (ignored while empty)
//   rd_data      - head entry, forced to 0 while empty
//   empty/full   - occupancy flags from (log2(DEPTH)+1)-bit wrapping pointers
module commit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  // extra MSB distinguishes full from empty when the index bits match
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/core_seq.sv
// core_seq: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 core.
//   clk, rst        - clock, synchronous active-high reset
//   if_req/if_ok    - fetch handshake, if_pc/if_instr captured on if_ok
//   dec_*           - decoded control fields, captured in DECODE
//   ex_start/ex_ok  - execute start pulse / multi-cycle completion
//   mem_req/mem_ok  - data access handshake
//   wb_data, rf_w   - writeback value and register-file write enable
//   cm              - commit channel (core_seq_if.master), one record per retire
//   wdog_trip       - sticky watchdog flag
// Optional: define CORE_SEQ_WDOG_EN to enable the per-state watchdog.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH       = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  output logic            if_req,
  input  logic            if_ok,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            dec_multi,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_rfw,
  input  logic            dec_skip,
  input  logic [4:0]      dec_rdc,
  output logic            ex_start,
  input  logic            ex_ok,
  output logic            mem_req,
  input  logic            mem_ok,
  input  logic [XLEN-1:0] wb_data,
  output logic            rf_w,
  core_seq_if.master      cm,
  output logic            wdog_trip
);
  seq_state_t      state, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            multi_q, mem_op_q, rfw_q, skip_q;
  logic [4:0]      rdc_q;

  logic            push, pop, fifo_full, fifo_empty;
  commit_rec_t     rec, head;

  assign pop = cm.cm_valid && cm.cm_ready;

`ifdef CORE_SEQ_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_cnt;
  logic          wdog_hit;
  logic          wdog_q;
`endif

  always_comb begin
    state_d  = state;
    if_req   = 1'b0;
    ex_start = 1'b0;
    mem_req  = 1'b0;
    rf_w     = 1'b0;
    push     = 1'b0;
    case (state)
      FETCH:  begin
        if_req = 1'b1;
        if (if_ok) state_d = DECODE;
      end
      DECODE: begin
        ex_start = 1'b1;
        state_d  = EXEC;
      end
      EXEC:   if (!multi_q || ex_ok) state_d = mem_op_q ? MEM : WB;
      MEM:    begin
        mem_req = 1'b1;
        if (mem_ok) state_d = WB;
      end
      WB:     begin
        // a pop this cycle frees the slot we are about to fill
        if (!fifo_full || pop) begin
          rf_w    = rfw_q;
          push    = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
`ifdef CORE_SEQ_WDOG_EN
    wdog_hit = 1'b0;
    // only fires while the state would otherwise hold; WB stalls are exempt
    if ((state == FETCH || state == EXEC || state == MEM) && state_d == state &&
        wdog_cnt == CW'(WDOG_CYCLES - 1)) begin
      wdog_hit = 1'b1;
      state_d  = FETCH;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc_q     <= '0;
      instr_q  <= '0;
      multi_q  <= 1'b0;
      mem_op_q <= 1'b0;
      rfw_q    <= 1'b0;
      skip_q   <= 1'b0;
      rdc_q    <= '0;
    end else begin
      state <= state_d;
      if (state == FETCH && if_ok) begin
        pc_q    <= if_pc;
        instr_q <= if_instr;
      end
      if (state == DECODE) begin
        multi_q  <= dec_multi;
        mem_op_q <= dec_load || dec_store;
        rfw_q    <= dec_rfw;
        skip_q   <= dec_skip;
        rdc_q    <= dec_rdc;
      end
    end
  end

`ifdef CORE_SEQ_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else begin
      if (wdog_hit || state_d != state) wdog_cnt <= '0;
      else                              wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_hit) wdog_q <= 1'b1;
    end
  end
  assign wdog_trip = wdog_q;
`else
  assign wdog_trip = 1'b0;
`endif

  // records are stored at full REC_XLEN width; narrower cores zero-extend
  always_comb begin
    rec                 = '0;
    rec.pc[XLEN-1:0]    = pc_q;
    rec.instr           = instr_q;
    rec.wen             = rfw_q;
    rec.rdc             = rdc_q;
    rec.wdata[XLEN-1:0] = wb_data;
    rec.skip            = skip_q;
  end

  commit_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (rec),
    .pop     (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign cm.cm_valid = !fifo_empty;
  assign cm.cm_pc    = head.pc[XLEN-1:0];
  assign cm.cm_instr = head.instr;
  assign cm.cm_wen   = head.wen;
  assign cm.cm_rdc   = head.rdc;
  assign cm.cm_wdata = head.wdata[XLEN-1:0];
  assign cm.cm_skip  = head.skip;
endmodule
